// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//   Front-panel time/alarm entry controller. It conditions three raw
//   push-buttons, walks the set-time / set-alarm editor and hands edited
//   values to the clock core through one-cycle load strobes. It also produces
//   a per-field blank mask so the LED driver can flash the field being edited.
//
// Ports
//   clk, rst_n                 system clock, asynchronous active-low reset
//   btn_mode/btn_next/btn_inc  raw buttons, active high, asynchronous
//   cur_hour/min/sec           current time from the clock core (binary)
//   cur_ahour/amin/asec        current alarm setting from the clock core
//   set_hour/min/sec           edit registers presented to the clock core
//   load_time                  1-cycle strobe: core loads set_* as time
//   load_alarm                 1-cycle strobe: core loads set_* as alarm
//   editing                    00 idle, 01 editing time, 10 editing alarm
//   blank                      {hour,min,sec} blank request, 1 = blank
// -----------------------------------------------------------------------------
module time_set_ctrl #(
   parameter int DEB_CYCLES = 1000000,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_next,
   input  logic       btn_inc,
   input  logic [7:0] cur_hour,
   input  logic [7:0] cur_min,
   input  logic [7:0] cur_sec,
   input  logic [7:0] cur_ahour,
   input  logic [7:0] cur_amin,
   input  logic [7:0] cur_asec,
   output logic [7:0] set_hour,
   output logic [7:0] set_min,
   output logic [7:0] set_sec,
   output logic       load_time,
   output logic       load_alarm,
   output logic [1:0] editing,
   output logic [2:0] blank
);

   localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int BLINK_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   localparam logic [7:0] HOUR_MAX = 8'd23;
   localparam logic [7:0] MS_MAX   = 8'd59;

   // Button vector index: 2 = mode, 1 = next, 0 = inc
   localparam int B_MODE = 2;
   localparam int B_NEXT = 1;
   localparam int B_INC  = 0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T_H  = 3'd1,
      T_M  = 3'd2,
      T_S  = 3'd3,
      A_H  = 3'd4,
      A_M  = 3'd5,
      A_S  = 3'd6
   } state_t;

   // Values outside the field range are treated as garbage and replaced by 0
   function automatic logic [7:0] clamp_field(input logic [7:0] v,
                                              input logic [7:0] vmax);
      return (v > vmax) ? 8'd0 : v;
   endfunction

   // Increment with wrap to 0 past the field maximum; no carry out
   function automatic logic [7:0] inc_wrap(input logic [7:0] v,
                                           input logic [7:0] vmax);
      return (v >= vmax) ? 8'd0 : v + 8'd1;
   endfunction

   function automatic logic [1:0] edit_code(input state_t s);
      case (s)
         T_H, T_M, T_S: return 2'b01;
         A_H, A_M, A_S: return 2'b10;
         default:       return 2'b00;
      endcase
   endfunction

   logic [2:0]       btn_raw;
   logic [2:0]       sync_p0;
   logic [2:0]       sync_p1;
   logic [2:0]       db_lvl;
   logic [2:0]       db_lvl_d;
   logic [DEB_W-1:0] deb_cnt [3];
   logic [2:0]       press;
   logic             ev_mode;
   logic             ev_next;
   logic             ev_inc;

   state_t           state;
   state_t           state_nx;
   logic [7:0]       hour_nx;
   logic [7:0]       min_nx;
   logic [7:0]       sec_nx;
   logic             load_time_nx;
   logic             load_alarm_nx;
   logic             blink_clr;
   logic [BLINK_W-1:0] blink_cnt;
   logic             blink_phase;

   assign btn_raw = {btn_mode, btn_next, btn_inc};

   // ---- stage p0/p1: two-flop synchronizer, then debounce ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0  <= '0;
         sync_p1  <= '0;
         db_lvl   <= '0;
         db_lvl_d <= '0;
         for (int i = 0; i < 3; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         sync_p0  <= btn_raw;
         sync_p1  <= sync_p0;
         db_lvl_d <= db_lvl;
         for (int i = 0; i < 3; i++) begin
            // Only an unbroken run of mismatching samples moves the level
            if (sync_p1[i] != db_lvl[i]) begin
               if (deb_cnt[i] == DEB_LAST) begin
                  db_lvl[i]  <= sync_p1[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   // Rising edge of the debounced level; a held button yields one pulse.
   // Priority mode > next > inc drops the weaker events of the same cycle.
   assign press   = db_lvl & ~db_lvl_d;
   assign ev_mode = press[B_MODE];
   assign ev_next = press[B_NEXT] & ~press[B_MODE];
   assign ev_inc  = press[B_INC]  & ~press[B_NEXT] & ~press[B_MODE];

   // ---- editor next-state ----
   always_comb begin
      state_nx      = state;
      hour_nx       = set_hour;
      min_nx        = set_min;
      sec_nx        = set_sec;
      load_time_nx  = 1'b0;
      load_alarm_nx = 1'b0;
      blink_clr     = 1'b0;

      case (state)
         IDLE: begin
            if (ev_mode) begin
               hour_nx   = clamp_field(cur_hour, HOUR_MAX);
               min_nx    = clamp_field(cur_min,  MS_MAX);
               sec_nx    = clamp_field(cur_sec,  MS_MAX);
               state_nx  = T_H;
               blink_clr = 1'b1;
            end
         end
         T_H, T_M, T_S, A_H, A_M, A_S: begin
            if (ev_mode) begin
               // Commit: set_* stays put while the strobe is high; the
               // alarm capture for the time->alarm hand-over happens after.
               if (edit_code(state) == 2'b01) begin
                  load_time_nx = 1'b1;
                  state_nx     = A_H;
               end else begin
                  load_alarm_nx = 1'b1;
                  state_nx      = IDLE;
               end
               blink_clr = 1'b1;
            end else if (ev_next) begin
               case (state)
                  T_H:     state_nx = T_M;
                  T_M:     state_nx = T_S;
                  T_S:     state_nx = T_H;
                  A_H:     state_nx = A_M;
                  A_M:     state_nx = A_S;
                  A_S:     state_nx = A_H;
                  default: state_nx = IDLE;
               endcase
               blink_clr = 1'b1;
            end else if (ev_inc) begin
               case (state)
                  T_H, A_H: hour_nx = inc_wrap(set_hour, HOUR_MAX);
                  T_M, A_M: min_nx  = inc_wrap(set_min,  MS_MAX);
                  T_S, A_S: sec_nx  = inc_wrap(set_sec,  MS_MAX);
                  default:  hour_nx = set_hour;
               endcase
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // The cycle carrying load_time is the one after which the edit
      // registers switch over to the alarm values.
      if (load_time) begin
         hour_nx = clamp_field(cur_ahour, HOUR_MAX);
         min_nx  = clamp_field(cur_amin,  MS_MAX);
         sec_nx  = clamp_field(cur_asec,  MS_MAX);
      end
   end

   // ---- stage p2: editor registers, strobes, blink timer ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         set_hour    <= '0;
         set_min     <= '0;
         set_sec     <= '0;
         load_time   <= 1'b0;
         load_alarm  <= 1'b0;
         editing     <= 2'b00;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         state      <= state_nx;
         set_hour   <= hour_nx;
         set_min    <= min_nx;
         set_sec    <= sec_nx;
         load_time  <= load_time_nx;
         load_alarm <= load_alarm_nx;
         editing    <= edit_code(state_nx);
         // Restart the blink on every field change so the newly selected
         // field is visible for a full phase before it first blanks.
         if (blink_clr || (state_nx == IDLE)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
         end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      blank = 3'b000;
      if (blink_phase) begin
         case (state)
            T_H, A_H: blank = 3'b100;
            T_M, A_M: blank = 3'b010;
            T_S, A_S: blank = 3'b001;
            default:  blank = 3'b000;
         endcase
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//   Bench for time_set_ctrl with DEB_CYCLES=4, BLINK_DIV=8. Expected load
//   strobes are queued when the committing button is pressed and compared by
//   a monitor when the DUT raises load_time or load_alarm.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_mode, btn_next, btn_inc;
   logic [7:0] cur_hour, cur_min, cur_sec;
   logic [7:0] cur_ahour, cur_amin, cur_asec;
   logic [7:0] set_hour, set_min, set_sec;
   logic       load_time, load_alarm;
   logic [1:0] editing;
   logic [2:0] blank;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic       is_alarm;
      logic [7:0] h;
      logic [7:0] m;
      logic [7:0] s;
      logic [1:0] ed;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic prev_load;
   bit   found;

   time_set_ctrl #(.DEB_CYCLES(4), .BLINK_DIV(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .cur_ahour(cur_ahour), .cur_amin(cur_amin), .cur_asec(cur_asec),
      .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
      .load_time(load_time), .load_alarm(load_alarm),
      .editing(editing), .blank(blank)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic check_set(input string tag, input int h, input int m,
                            input int s);
      check({tag, "_hour"}, 32'(set_hour), 32'(h));
      check({tag, "_min"},  32'(set_min),  32'(m));
      check({tag, "_sec"},  32'(set_sec),  32'(s));
   endtask

   task automatic push_exp(input logic a, input int h, input int m,
                           input int s, input logic [1:0] ed);
      exp_t e;
      e.is_alarm = a;
      e.h = 8'(h);
      e.m = 8'(m);
      e.s = 8'(s);
      e.ed = ed;
      sb.push_back(e);
   endtask

   task automatic drive_btn(input logic [2:0] b);
      @(posedge clk);
      #1;
      {btn_mode, btn_next, btn_inc} = b;
   endtask

   // Clean press: long enough high and low for the debouncer to settle
   task automatic press(input logic [2:0] b);
      drive_btn(b);
      repeat (10) @(posedge clk);
      drive_btn(3'b000);
      repeat (10) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_cur(input int h, input int m, input int s);
      cur_hour = 8'(h);
      cur_min  = 8'(m);
      cur_sec  = 8'(s);
   endtask

   // Load strobe monitor / scoreboard consumer
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_load <= 1'b0;
      end else begin
         if (load_time || load_alarm) begin
            check("load_pulse_width", 32'(prev_load), 0);
            check("load_exclusive", 32'(load_time & load_alarm), 0);
            if (sb.size() == 0) begin
               check("sb_unexpected_load", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check("sb_kind_alarm", 32'(load_alarm), 32'(mon_e.is_alarm));
               check("sb_hour", 32'(set_hour), 32'(mon_e.h));
               check("sb_min",  32'(set_min),  32'(mon_e.m));
               check("sb_sec",  32'(set_sec),  32'(mon_e.s));
               check("sb_editing", 32'(editing), 32'(mon_e.ed));
            end
         end
         prev_load <= load_time | load_alarm;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      {btn_mode, btn_next, btn_inc} = 3'b000;
      set_cur(0, 0, 0);
      cur_ahour = 8'd6; cur_amin = 8'd30; cur_asec = 8'd0;

      // Reset state
      repeat (3) @(negedge clk);
      check_set("rst", 0, 0, 0);
      check("rst_load_time", 32'(load_time), 0);
      check("rst_load_alarm", 32'(load_alarm), 0);
      check("rst_editing", 32'(editing), 0);
      check("rst_blank", 32'(blank), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_editing", 32'(editing), 0);

      // Enter time edit; verify the blink cadence on the hour field
      set_cur(12, 34, 56);
      drive_btn(3'b100);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (editing == 2'b01) found = 1'b1;
      end
      check("enter_th_seen", 32'(found), 1);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("blink_%0d", i), 32'(blank),
               (i >= 8) ? 32'd4 : 32'd0);
         @(negedge clk);
      end
      drive_btn(3'b000);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("th_editing", 32'(editing), 1);
      check_set("capture_time", 12, 34, 56);

      // Time set path: next, inc x3, mode
      press(3'b010);
      for (int i = 0; i < 3; i++) press(3'b001);
      check_set("min_inc3", 12, 37, 56);
      push_exp(1'b0, 12, 37, 56, 2'b10);
      press(3'b100);
      check("to_alarm_editing", 32'(editing), 2);
      check_set("capture_alarm", 6, 30, 0);

      // Alarm commit from A_S
      press(3'b010);
      press(3'b010);
      push_exp(1'b1, 6, 30, 0, 2'b00);
      press(3'b100);
      check("alarm_commit_editing", 32'(editing), 0);
      check("alarm_commit_blank", 32'(blank), 0);
      check_set("alarm_commit_held", 6, 30, 0);

      // Wrap and bounce rejection
      set_cur(23, 10, 59);
      press(3'b100);
      check_set("capture_2", 23, 10, 59);
      press(3'b001);
      check("hour_wrap", 32'(set_hour), 0);
      press(3'b010);
      for (int i = 0; i < 20; i++) begin
         drive_btn({2'b00, ((i >> 1) & 1) == 0});
      end
      drive_btn(3'b001);
      repeat (10) @(posedge clk);
      drive_btn(3'b000);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("bounce_min", 32'(set_min), 11);
      drive_btn(3'b001);
      repeat (2) @(posedge clk);
      drive_btn(3'b000);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("glitch_min", 32'(set_min), 11);
      press(3'b010);
      press(3'b001);
      check("sec_wrap", 32'(set_sec), 0);
      check("sec_wrap_min_kept", 32'(set_min), 11);
      push_exp(1'b0, 0, 11, 0, 2'b10);
      press(3'b100);
      push_exp(1'b1, 6, 30, 0, 2'b00);
      press(3'b100);
      check("idle_again", 32'(editing), 0);

      // Capture clamp of out-of-range current time
      set_cur(30, 60, 59);
      press(3'b100);
      check_set("capture_clamp", 0, 0, 59);

      // Priority: mode and inc in the same cycle in T_H
      push_exp(1'b0, 0, 0, 59, 2'b10);
      press(3'b101);
      check("prio_editing", 32'(editing), 2);
      check_set("prio_alarm_capture", 6, 30, 0);
      push_exp(1'b1, 6, 30, 0, 2'b00);
      press(3'b100);

      // Asynchronous reset in the middle of an edit
      set_cur(12, 34, 56);
      press(3'b100);
      press(3'b010);
      press(3'b010);
      check("ts_editing", 32'(editing), 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_editing", 32'(editing), 0);
      check_set("midrst", 0, 0, 0);
      check("midrst_blank", 32'(blank), 0);
      check("midrst_loads", 32'({load_time, load_alarm}), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      press(3'b001);
      press(3'b010);
      check("idle_ignore_editing", 32'(editing), 0);
      check_set("idle_ignore", 0, 0, 0);
      press(3'b100);
      check("after_rst_mode", 32'(editing), 1);
      check_set("after_rst_capture", 12, 34, 56);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
